// File: rtl/pipe_sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_sram_arbiter_pkg
//  Description : Shared definitions for the pipeline SRAM arbiter: FSM state
//                encoding (binary or one-hot), wait-state counter width and
//                the active-low SRAM strobe levels.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_sram_arbiter_pkg;

    // Set to 1'b1 to switch the arbiter FSM to one-hot state encoding.
    localparam bit c_ONE_HOT = 1'b0;
    localparam int c_STATE_W = c_ONE_HOT ? 4 : 2;

    localparam logic [c_STATE_W-1:0] c_ENC_IDLE   = c_ONE_HOT ? c_STATE_W'(4'b0001) : c_STATE_W'(2'd0);
    localparam logic [c_STATE_W-1:0] c_ENC_SETUP  = c_ONE_HOT ? c_STATE_W'(4'b0010) : c_STATE_W'(2'd1);
    localparam logic [c_STATE_W-1:0] c_ENC_ACCESS = c_ONE_HOT ? c_STATE_W'(4'b0100) : c_STATE_W'(2'd2);
    localparam logic [c_STATE_W-1:0] c_ENC_DONE   = c_ONE_HOT ? c_STATE_W'(4'b1000) : c_STATE_W'(2'd3);

    typedef enum logic [c_STATE_W-1:0] {
        IDLE   = c_ENC_IDLE,
        SETUP  = c_ENC_SETUP,
        ACCESS = c_ENC_ACCESS,
        DONE   = c_ENC_DONE
    } state_e;

    // Wait-state counter: covers WAIT = 0..7.
    localparam int c_CNT_W    = 3;
    localparam int c_WAIT_MAX = 7;

    // SRAM control strobes are active low.
    localparam logic c_SRAM_ACT  = 1'b0;
    localparam logic c_SRAM_IDLE = 1'b1;

endpackage : pipe_sram_arbiter_pkg
`default_nettype wire

// File: rtl/pipe_sram_arbiter_prio_select.sv
`default_nettype none
// ============================================================================
//  Module      : prio_select
//  Description : Fixed-priority selector; the lowest-index active request wins.
//  Ports       : i_req   - request vector
//                o_grant - one-hot grant (all zero when nothing requests)
//                o_valid - at least one request is active
//  Revision    : 1.0  initial release
// ============================================================================
module prio_select
    import pipe_sram_arbiter_pkg::*;
#(
    parameter int NPORT = 2
) (
    input  logic [NPORT-1:0] i_req,
    output logic [NPORT-1:0] o_grant,
    output logic             o_valid
);

    // x & (~x + 1) isolates the least-significant set bit.
    assign o_grant = i_req & (~i_req + NPORT'(1));
    assign o_valid = |i_req;

endmodule : prio_select
`default_nettype wire

// File: rtl/pipe_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_sram_arbiter
//  Description : Arbitrates NPORT pipeline requesters (port 0 = MEM stage,
//                port NPORT-1 = instruction fetch) onto one asynchronous SRAM.
//                Each access runs IDLE -> SETUP -> ACCESS (WAIT+1 cycles) ->
//                DONE -> IDLE, so latency is 3+WAIT and throughput 1/(4+WAIT).
//  Ports       : CLK, RST          - clock, async active-high reset
//                req/we/addr/wdata - per-port request bundle (held until ack)
//                ack, rdata, stall - per-port completion, read data, stall
//                ramEN/OE/WE       - active-low SRAM strobes
//                ramAddr, ramData  - SRAM address and bidirectional data bus
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_sram_arbiter
    import pipe_sram_arbiter_pkg::*;
#(
    parameter int          DW    = 16,
    parameter int          AW    = 18,
    parameter int          NPORT = 2,
    parameter int unsigned WAIT  = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NPORT-1:0]    req,
    input  logic [NPORT-1:0]    we,
    input  logic [NPORT*AW-1:0] addr,
    input  logic [NPORT*DW-1:0] wdata,
    output logic [NPORT-1:0]    ack,
    output logic [DW-1:0]       rdata,
    output logic [NPORT-1:0]    stall,
    output logic                ramEN,
    output logic                ramOE,
    output logic                ramWE,
    output logic [AW-1:0]       ramAddr,
    inout  wire  [DW-1:0]       ramData
);

    state_e               r_state;
    state_e               w_nextState;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [NPORT-1:0]     r_grant;
    logic                 r_we;
    logic [AW-1:0]        r_addr;
    logic [DW-1:0]        r_wdata;
    logic [DW-1:0]        r_rdata;
    logic                 r_live;      // granted port has held req throughout

    logic [NPORT-1:0]     w_selGrant;
    logic                 w_selValid;
    logic                 w_selWe;
    logic [AW-1:0]        w_selAddr;
    logic [DW-1:0]        w_selWdata;
    logic                 w_cntDone;
    logic                 w_grantReq;
    logic                 w_drive;

    prio_select #(
        .NPORT (NPORT)
    ) u_prio (
        .i_req   (req),
        .o_grant (w_selGrant),
        .o_valid (w_selValid)
    );

    // One-hot mux of the winning port's request bundle.
    always_comb begin
        w_selWe    = 1'b0;
        w_selAddr  = '0;
        w_selWdata = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (w_selGrant[i]) begin
                w_selWe    = we[i];
                w_selAddr  = addr[i*AW +: AW];
                w_selWdata = wdata[i*DW +: DW];
            end
        end
    end

    assign w_cntDone  = (r_cnt == c_CNT_W'(WAIT));
    assign w_grantReq = |(req & r_grant);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        ramEN       = c_SRAM_IDLE;
        ramOE       = c_SRAM_IDLE;
        ramWE       = c_SRAM_IDLE;
        w_drive     = 1'b0;
        ack         = '0;
        case (r_state)
            IDLE: begin
                if (w_selValid) begin
                    w_nextState = SETUP;
                end
            end
            SETUP: begin
                // Address and data settle here before the WE strobe.
                ramEN       = c_SRAM_ACT;
                ramOE       = r_we ? c_SRAM_IDLE : c_SRAM_ACT;
                w_drive     = r_we;
                w_nextState = ACCESS;
            end
            ACCESS: begin
                ramEN = c_SRAM_ACT;
                if (r_we) begin
                    ramWE   = c_SRAM_ACT;
                    w_drive = 1'b1;
                end else begin
                    ramOE   = c_SRAM_ACT;
                end
                if (w_cntDone) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                // Write data held one extra cycle after WE rises (hold time).
                w_drive     = r_we;
                if (r_live) begin
                    ack = r_grant & req;
                end
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // ------------------------------------------------- grant latch / datapath
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt   <= '0;
            r_grant <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_live  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_selValid) begin
                        r_grant <= w_selGrant;
                        r_we    <= w_selWe;
                        r_addr  <= w_selAddr;
                        r_wdata <= w_selWdata;
                        r_live  <= 1'b1;
                    end
                end
                SETUP: begin
                    r_cnt <= '0;
                    if (!w_grantReq) begin
                        r_live <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (!w_cntDone) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else if (!r_we) begin
                        r_rdata <= ramData;
                    end
                    if (!w_grantReq) begin
                        r_live <= 1'b0;
                    end
                end
                DONE: begin
                    r_cnt <= '0;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign stall   = req & ~ack;
    assign rdata   = r_rdata;
    assign ramAddr = r_addr;
    assign ramData = w_drive ? r_wdata : {DW{1'bz}};

endmodule : pipe_sram_arbiter
`default_nettype wire
